count_control: RTL and testbench
================================

COUNT_CONTROL -- requirements
Module: count_control

Interface
REQ-001 Parameter PASSES, default 1, number of complete 0->3 count sweeps per START; legal range 1..15.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request to begin a run; sampled only in IDLE.
REQ-005 ABORT  input  1  request to cancel a run; sampled in every state.
REQ-006 INC_OUT  input  2  incremented value returned from the incrementer datapath (COUNT+1 mod 4).
REQ-007 NOT_EQUAL_3  input  1  registered terminal flag from the incrementer; 0 means COUNT has reached 3.
REQ-008 COUNT  output  2  count register; drives the incrementer IN port.
REQ-009 PASS_CNT  output  4  index of the current sweep, 0-based.
REQ-010 BUSY  output  1  high while in LOAD or RUN.
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 ERR  output  1  sticky datapath-consistency error flag.

Function
REQ-013 FSM SHALL have four states: IDLE, LOAD, RUN, FIN.
REQ-014 IDLE: COUNT held at 0, PASS_CNT held at 0; START=1 and ABORT=0 -> LOAD.
REQ-015 LOAD: COUNT <= 0; next state RUN unconditionally (one settling cycle so that NOT_EQUAL_3 reflects COUNT=0).
REQ-016 RUN with NOT_EQUAL_3=1: COUNT <= INC_OUT, remain in RUN.
REQ-017 RUN with NOT_EQUAL_3=0 and PASS_CNT < PASSES-1: PASS_CNT <= PASS_CNT+1, COUNT <= 0, next state LOAD.
REQ-018 RUN with NOT_EQUAL_3=0 and PASS_CNT = PASSES-1: COUNT held at 3, next state FIN.
REQ-019 FIN: DONE=1 for exactly this one cycle; next state IDLE; COUNT <= 0, PASS_CNT <= 0.
REQ-020 Each sweep SHALL take 5 cycles (1 LOAD + 4 RUN with COUNT 0,1,2,3); FIN is entered on the 5*PASSES-th rising edge after the edge that sampled START.
REQ-021 START while not in IDLE SHALL be ignored (no queuing).
REQ-022 ABORT=1 in any state SHALL force IDLE on the next edge, clear COUNT and PASS_CNT, and suppress DONE; ABORT wins over a simultaneous START.
REQ-023 ABORT in FIN SHALL still allow the current DONE cycle but force IDLE next (same as normal exit).
REQ-024 BUSY and DONE SHALL be decoded from the state register only (glitch-free, no combinational path from inputs).
REQ-025 PASS_CNT arithmetic is 4-bit unsigned; it never wraps, since it is bounded by PASSES-1 <= 14.

Reset
REQ-026 RST=1 on a rising edge SHALL force IDLE, COUNT=0, PASS_CNT=0, BUSY=0, DONE=0, ERR=0, regardless of other inputs, including mid-run.
REQ-027 The first cycle after RST deasserts SHALL be a normal IDLE cycle that accepts START.

Configuration
REQ-028 Macro COUNT_CONTROL_CHECK_EN, when defined, SHALL enable the consistency checker: in RUN, ERR is set if INC_OUT != COUNT+1 (mod 4), or if NOT_EQUAL_3=0 while COUNT!=3; ERR is cleared only by RST.
REQ-029 Without COUNT_CONTROL_CHECK_EN, the ERR port SHALL remain present and tied to 0, and no checker logic is synthesised.

Verification
REQ-030 PASSES=1, reset then START pulse at edge E0 -> COUNT 0,0,1,2,3 over E0..E4, DONE=1 only after E5, BUSY=1 for exactly 5 cycles.
REQ-031 PASSES=3, START -> COUNT sequence (0,0,1,2,3) repeated 3 times, PASS_CNT 0->1->2, single DONE pulse after the 15th edge.
REQ-032 ABORT asserted during the second RUN cycle -> IDLE next cycle, COUNT=0, no DONE pulse; a subsequent START runs the full sequence normally.
REQ-033 START held high continuously -> new run only after returning to IDLE; no START accepted while BUSY=1; START and ABORT together in IDLE -> stays in IDLE.
REQ-034 RST asserted with COUNT=2 in RUN -> all outputs at reset values after that edge; DONE never pulses.
REQ-035 With COUNT_CONTROL_CHECK_EN, force INC_OUT=0 while COUNT=1 -> ERR=1 from the next edge and held until RST; without the macro, same stimulus -> ERR=0.

Source files
------------

// File: rtl/count_control.sv
// count_control: sequences PASSES sweeps of a 2-bit counter through an external incrementer
//
// Ports:
//   CLK          system clock, all state changes on its rising edge
//   RST          synchronous active-high reset
//   START        begin a run (sampled in IDLE only)
//   ABORT        cancel a run (sampled in every state, wins over START)
//   INC_OUT      COUNT+1 mod 4 returned by the incrementer
//   NOT_EQUAL_3  incrementer terminal flag, 0 once COUNT has reached 3
//   COUNT        count register, drives the incrementer input
//   PASS_CNT     0-based index of the current sweep
//   BUSY         high in LOAD or RUN
//   DONE         one-cycle completion pulse in FIN
//   ERR          sticky datapath-consistency error
//
// Build option: define COUNT_CONTROL_CHECK_EN to enable the consistency checker
// driving ERR; otherwise ERR is tied low and no checker logic exists.
module count_control #(
    parameter int unsigned PASSES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic [1:0] INC_OUT,
    input  logic       NOT_EQUAL_3,
    output logic [1:0] COUNT,
    output logic [3:0] PASS_CNT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
    localparam logic [3:0] LAST = 4'(PASSES - 1);
    state_t state;
    always_ff @(posedge CLK) begin
        if (RST || ABORT) begin
            state    <= IDLE;
            COUNT    <= 2'd0;
            PASS_CNT <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    COUNT    <= 2'd0;
                    PASS_CNT <= 4'd0;
                    if (START) state <= LOAD;
                end
                // LOAD gives the incrementer one cycle to see COUNT=0
                LOAD: begin
                    COUNT <= 2'd0;
                    state <= RUN;
                end
                RUN: begin
                    if (NOT_EQUAL_3) begin
                        COUNT <= INC_OUT;
                    end else if (PASS_CNT < LAST) begin
                        PASS_CNT <= PASS_CNT + 4'd1;
                        COUNT    <= 2'd0;
                        state    <= LOAD;
                    end else begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    COUNT    <= 2'd0;
                    PASS_CNT <= 4'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end
    // Status decoded purely from the state register, so no input reaches them
    assign BUSY = (state == LOAD) || (state == RUN);
    assign DONE = (state == FIN);
`ifdef COUNT_CONTROL_CHECK_EN
    logic err_q;
    always_ff @(posedge CLK) begin
        if (RST)
            err_q <= 1'b0;
        else if (state == RUN && ((INC_OUT != COUNT + 2'd1) || (!NOT_EQUAL_3 && COUNT != 2'd3)))
            err_q <= 1'b1;
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_count_control.sv
// tb_count_control: directed self-checking bench for count_control
module tb_count_control;
    logic       CLK = 1'b0;
    logic       RST, START, ABORT, force1;
    logic [1:0] count1, count3, inc1, inc3;
    logic [3:0] pass1, pass3;
    logic       busy1, busy3, done1, done3, err1, err3, ne1, ne3;
    int checks = 0;
    int errors = 0;
`ifdef COUNT_CONTROL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    // behavioural incrementers; force1 corrupts INC_OUT of the single-pass DUT
    assign inc1 = force1 ? 2'd0 : count1 + 2'd1;
    assign ne1  = (count1 != 2'd3);
    assign inc3 = count3 + 2'd1;
    assign ne3  = (count3 != 2'd3);

    count_control #(.PASSES(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .INC_OUT(inc1),
        .NOT_EQUAL_3(ne1), .COUNT(count1), .PASS_CNT(pass1), .BUSY(busy1),
        .DONE(done1), .ERR(err1)
    );
    count_control #(.PASSES(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .INC_OUT(inc3),
        .NOT_EQUAL_3(ne3), .COUNT(count3), .PASS_CNT(pass3), .BUSY(busy3),
        .DONE(done3), .ERR(err3)
    );

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; force1 = 1'b0;
        step;
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; START = 1'b1; ABORT = 1'b0; force1 = 1'b0;
        step;
        RST = 1'b0; START = 1'b0;
        checks++;
        if ({count1, pass1, busy1, done1, err1} !== 9'd0) begin
            errors++;
            $display("FAIL reset_p1 got cnt=%0d pass=%0d busy=%b done=%b err=%b want all 0", count1, pass1, busy1, done1, err1);
        end
        checks++;
        if ({count3, pass3, busy3, done3, err3} !== 9'd0) begin
            errors++;
            $display("FAIL reset_p3 got cnt=%0d pass=%0d busy=%b done=%b err=%b want all 0", count3, pass3, busy3, done3, err3);
        end
    endtask

    // one full PASSES=1 run, checked after E0..E6
    task automatic test_single;
        logic [1:0] ec [7] = '{0, 0, 1, 2, 3, 3, 0};
        logic       eb [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic       ed [7] = '{0, 0, 0, 0, 0, 1, 0};
        START = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step;
            START = 1'b0;
            checks++;
            if ({count1, pass1, busy1, done1} !== {ec[k], 4'd0, eb[k], ed[k]}) begin
                errors++;
                $display("FAIL single_E%0d got cnt=%0d pass=%0d busy=%b done=%b want cnt=%0d pass=0 busy=%b done=%b",
                         k, count1, pass1, busy1, done1, ec[k], eb[k], ed[k]);
            end
        end
    endtask

    task automatic test_passes3;
        logic [1:0] ec [5] = '{0, 0, 1, 2, 3};
        logic [1:0] xc;
        logic [3:0] xp;
        logic       xb, xd;
        do_reset;
        START = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step;
            START = 1'b0;
            xc = (k < 15) ? ec[k % 5] : (k == 15 ? 2'd3 : 2'd0);
            xp = (k < 15) ? 4'(k / 5) : (k == 15 ? 4'd2 : 4'd0);
            xb = (k < 15);
            xd = (k == 15);
            checks++;
            if ({count3, pass3, busy3, done3} !== {xc, xp, xb, xd}) begin
                errors++;
                $display("FAIL passes3_E%0d got cnt=%0d pass=%0d busy=%b done=%b want cnt=%0d pass=%0d busy=%b done=%b",
                         k, count3, pass3, busy3, done3, xc, xp, xb, xd);
            end
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        do_reset;
        START = 1'b1;
        step;
        START = 1'b0;
        step;
        step;
        checks++;
        if (count1 !== 2'd1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got cnt=%0d busy=%b want cnt=1 busy=1", count1, busy1);
        end
        ABORT = 1'b1;
        step;
        ABORT = 1'b0;
        checks++;
        if ({count1, pass1, busy1, done1} !== 8'd0) begin
            errors++;
            $display("FAIL abort_idle got cnt=%0d pass=%0d busy=%b done=%b want all 0", count1, pass1, busy1, done1);
        end
        for (int k = 0; k < 6; k++) begin
            step;
            if (done1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d DONE cycles want 0", dones);
        end
        test_single;
    endtask

    task automatic test_back_to_back;
        logic eb [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
        logic ed [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        do_reset;
        START = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step;
            checks++;
            if ({busy1, done1} !== {eb[k], ed[k]}) begin
                errors++;
                $display("FAIL b2b_E%0d got busy=%b done=%b want busy=%b done=%b", k, busy1, done1, eb[k], ed[k]);
            end
        end
        ABORT = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step;
            checks++;
            if ({busy1, done1, count1} !== 4'd0) begin
                errors++;
                $display("FAIL b2b_start_abort%0d got busy=%b done=%b cnt=%0d want 0", k, busy1, done1, count1);
            end
        end
        ABORT = 1'b0; START = 1'b0;
    endtask

    task automatic test_rst_mid;
        int dones = 0;
        do_reset;
        START = 1'b1;
        step;
        START = 1'b0;
        repeat (3) step;
        checks++;
        if (count1 !== 2'd2 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got cnt=%0d busy=%b want cnt=2 busy=1", count1, busy1);
        end
        RST = 1'b1; START = 1'b1;
        step;
        RST = 1'b0; START = 1'b0;
        checks++;
        if ({count1, pass1, busy1, done1, err1} !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_state got cnt=%0d pass=%0d busy=%b done=%b err=%b want all 0", count1, pass1, busy1, done1, err1);
        end
        for (int k = 0; k < 7; k++) begin
            step;
            if (done1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rstmid_nodone got %0d DONE cycles want 0", dones);
        end
        RST = 1'b1;
        step;
        RST = 1'b0; START = 1'b1;
        step;
        START = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_start got busy=%b want 1", busy1);
        end
    endtask

    task automatic test_err;
        do_reset;
        START = 1'b1;
        step;
        START = 1'b0;
        step;
        step;
        checks++;
        if (count1 !== 2'd1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_pre got cnt=%0d err=%b want cnt=1 err=0", count1, err1);
        end
        force1 = 1'b1;
        step;
        force1 = 1'b0;
        checks++;
        if (err1 !== ERR_EXP) begin
            errors++;
            $display("FAIL err_set got %b want %b", err1, ERR_EXP);
        end
        repeat (3) step;
        ABORT = 1'b1;
        step;
        ABORT = 1'b0;
        step;
        checks++;
        if (err1 !== ERR_EXP) begin
            errors++;
            $display("FAIL err_sticky got %b want %b", err1, ERR_EXP);
        end
        checks++;
        if (err3 !== 1'b0) begin
            errors++;
            $display("FAIL err_other got %b want 0", err3);
        end
        RST = 1'b1;
        step;
        RST = 1'b0;
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err1);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_passes3;
        test_abort;
        test_back_to_back;
        test_rst_mid;
        test_err;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
